uart_instr_loader: RTL and testbench

- Boot-time program loader sitting directly upstream of the instruction memory.
- Receives a framed program image on the serial `rx` line and assembles little-endian 32-bit instruction words.
- Drives the instruction memory's write port (`wr_en`/`wr_addr`/`wr_instr`).
- Holds the core in reset until a load completes with a valid checksum.

---
 rtl/loader_pkg.sv | 8 +
 rtl/uart_rx.sv | 75 +++++++
 rtl/uart_instr_loader.sv | 94 +++++++++
 tb/tb_uart_instr_loader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared frame-FSM states and constants for the UART instruction loader
package loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} loader_state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  function automatic logic is_busy(input loader_state_t s);
    return s inside {LEN_LO, LEN_HI, DATA, CHECK};
  endfunction
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop synchronizer, mid-bit sampling and start-glitch rejection
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t state, state_nx;
  logic [2:0] sync;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0] bit_idx, bit_idx_nx;
  logic [7:0] shift, shift_nx;
  logic valid_nx, ferr_nx, rx_s, fall, half, tick;
  // sync[1] is the synchronized line; sync[2] is its previous value for edge detection
  assign rx_s = sync[1];
  assign fall = sync[2] & ~sync[1];
  assign half = cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  assign byte_out = shift;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt + 1'b1;
    bit_idx_nx = bit_idx;
    shift_nx = shift;
    valid_nx = 1'b0;
    ferr_nx = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_nx = '0;
        state_nx = fall ? RX_START : RX_IDLE;
      end
      RX_START: if (half) begin
        cnt_nx = '0;
        bit_idx_nx = '0;
        state_nx = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (tick) begin
        cnt_nx = '0;
        shift_nx = {rx_s, shift[7:1]};
        bit_idx_nx = bit_idx + 1'b1;
        state_nx = bit_idx == 3'd7 ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (tick) begin
        state_nx = RX_IDLE;
        valid_nx = rx_s;
        ferr_nx = ~rx_s;
      end
      default: state_nx = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RX_IDLE;
      sync <= '1;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_nx;
      sync <= {sync[1:0], rx};
      cnt <= cnt_nx;
      bit_idx <= bit_idx_nx;
      shift <= shift_nx;
      byte_valid <= valid_nx;
      frame_err <= ferr_nx;
    end
endmodule

// File: rtl/uart_instr_loader.sv
// uart_instr_loader: boot loader that writes a framed UART program image into instruction memory
module uart_instr_loader
  import loader_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int MEM_DEPTH   = 256,
  parameter int ADDR_W      = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_instr,
  output logic              core_rst_n,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  loader_state_t state, state_nx;
  logic [7:0] rx_byte, chk;
  logic byte_valid, frame_err, last_word;
  logic [15:0] len, n_rx;
  logic [ADDR_W:0] word_idx;
  logic [1:0] byte_cnt;
  logic [23:0] word_lo;
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .byte_out  (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );
  assign n_rx = {rx_byte, len[7:0]};
  assign last_word = 16'(word_idx) == len - 16'd1;
  always_comb begin
    state_nx = state;
    if (frame_err && is_busy(state))
      state_nx = ERROR;
    else if (byte_valid)
      case (state)
        LEN_LO:  state_nx = LEN_HI;
        LEN_HI:  state_nx = n_rx > 16'(MEM_DEPTH) ? ERROR : n_rx == 16'd0 ? CHECK : DATA;
        DATA:    state_nx = byte_cnt == 2'd3 && last_word ? CHECK : DATA;
        CHECK:   state_nx = rx_byte == chk ? DONE : ERROR;
        default: state_nx = rx_byte == SYNC_BYTE ? LEN_LO : state;
      endcase
  end
  // status outputs are registered from the next state so they switch with the FSM, glitch-free
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      len <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      word_lo <= '0;
      chk <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_instr <= '0;
      core_rst_n <= 1'b0;
      busy <= 1'b0;
      load_done <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state <= state_nx;
      core_rst_n <= state_nx == DONE;
      load_done <= state_nx == DONE;
      load_err <= state_nx == ERROR;
      busy <= is_busy(state_nx);
      wr_en <= 1'b0;
      if (byte_valid && state == LEN_LO) len[7:0] <= rx_byte;
      if (byte_valid && state == LEN_HI) begin
        len[15:8] <= rx_byte;
        word_idx <= '0;
        byte_cnt <= '0;
        chk <= '0;
      end
      if (byte_valid && state == DATA) begin
        word_lo <= {rx_byte, word_lo[23:8]};
        chk <= chk ^ rx_byte;
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          wr_en <= 1'b1;
          wr_addr <= word_idx[ADDR_W-1:0];
          wr_instr <= {rx_byte, word_lo};
          word_idx <= word_idx + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_uart_instr_loader.sv
// tb_uart_instr_loader: directed frames checked against a scoreboard of expected memory writes and load outcomes
module tb_uart_instr_loader;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic wr_en, core_rst_n, busy, load_done, load_err;
  logic [7:0] wr_addr;
  logic [31:0] wr_instr;
  int checks = 0, errors = 0;
  logic [31:0] ea_q[$], ed_q[$], got_a[$], got_d[$];
  logic [31:0] last_a = '0, last_d = '0;
  logic [31:0] img [4];
  logic [7:0] c;
  logic word_end = 1'b0, pend = 1'b0;

  uart_instr_loader #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_instr  (wr_instr),
    .core_rst_n(core_rst_n),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flags(input string nm, input logic d, input logic e, input logic b);
    check({nm, " load_done"}, 32'(load_done), 32'(d));
    check({nm, " load_err"}, 32'(load_err), 32'(e));
    check({nm, " core_rst_n"}, 32'(core_rst_n), 32'(d));
    check({nm, " busy"}, 32'(busy), 32'(b));
  endtask

  task automatic bit_time(input logic v, input int n = 10);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    if (!stop) bit_time(1'b1);
  endtask

  // Sends LEN, img[0..n-1] little-endian and CHK (xor of data bytes, optionally corrupted);
  // the image succeeds exactly when the checksum is left intact.
  task automatic load_image(input logic sync, input int n, input logic [7:0] flip);
    logic [7:0] x;
    x = 8'h00;
    if (sync) send_byte(8'hA5);
    send_byte(8'(n));
    send_byte(8'(n >> 8));
    for (int i = 0; i < n; i++) begin
      ea_q.push_back(32'(i));
      ed_q.push_back(img[i]);
      for (int k = 0; k < 4; k++) begin
        x ^= img[i][8*k +: 8];
        word_end = (k == 3);
        send_byte(img[i][8*k +: 8]);
      end
    end
    c = x ^ flip;
    send_byte(c);
    check("writes drained", 32'(ea_q.size()), 32'd0);
    flags("image", flip == 8'h00, flip != 8'h00, 1'b0);
  endtask

  // Every write must land one cycle after the byte that completes a word, in order,
  // and the write port must hold its last values otherwise.
  initial forever begin
    @(negedge clk);
    if (!rst_n) pend = 1'b0;
    else begin
      if (pend) check("wr_en latency", 32'(wr_en), 32'd1);
      if (wr_en && pend && ea_q.size() > 0) begin
        last_a = ea_q.pop_front();
        last_d = ed_q.pop_front();
        check("wr_addr", 32'(wr_addr), last_a);
        check("wr_instr", wr_instr, last_d);
        got_a.push_back(32'(wr_addr));
        got_d.push_back(wr_instr);
      end else if (wr_en) begin
        checks++;
        errors++;
        $display("FAIL unexpected write: addr %h instr %h", wr_addr, wr_instr);
      end else begin
        check("wr_addr hold", 32'(wr_addr), last_a);
        check("wr_instr hold", wr_instr, last_d);
      end
      pend = dut.u_rx.byte_valid && word_end;
      if (pend) word_end = 1'b0;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset wr_en", 32'(wr_en), 32'd0);
    check("reset wr_addr", 32'(wr_addr), 32'd0);
    check("reset wr_instr", wr_instr, 32'd0);
    flags("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    bit_time(1'b1, 5);
    // noise before sync, then a short low glitch while waiting for LEN_LO
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    flags("noise", 1'b0, 1'b0, 1'b0);
    send_byte(8'hA5);
    flags("sync", 1'b0, 1'b0, 1'b1);
    bit_time(1'b0, 3);
    bit_time(1'b1, 20);
    img = '{32'h00000013, 32'h00100093, 32'h0, 32'h0};
    load_image(1'b0, 2, 8'h00);
    check("nominal chk byte", 32'(c), 32'h90);
    check("nominal write count", 32'(got_a.size()), 32'd2);
    if (got_a.size() == 2) begin
      check("nominal addr0", got_a[0], 32'd0);
      check("nominal instr0", got_d[0], 32'h00000013);
      check("nominal addr1", got_a[1], 32'd1);
      check("nominal instr1", got_d[1], 32'h00100093);
    end
    // reload from DONE re-holds the core and restarts at address 0
    send_byte(8'hA5);
    flags("reload sync", 1'b0, 1'b0, 1'b1);
    got_a.delete();
    got_d.delete();
    img = '{32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'h0};
    load_image(1'b0, 3, 8'h00);
    check("reload first addr", got_a.size() > 0 ? got_a[0] : 32'hFFFF_FFFF, 32'd0);
    // bad checksum: both writes still happen
    img = '{32'h00000013, 32'h00100093, 32'h0, 32'h0};
    load_image(1'b1, 2, 8'h01);
    check("bad chk byte", 32'(c), 32'h91);
    // oversize length 257
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    flags("oversize", 1'b0, 1'b1, 1'b0);
    // zero length
    load_image(1'b1, 0, 8'h00);
    check("zero chk byte", 32'(c), 32'h00);
    // framing error inside DATA, then one outside a frame
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00, 1'b0);
    flags("frame err", 1'b0, 1'b1, 1'b0);
    send_byte(8'h00, 1'b0);
    flags("frame err idle", 1'b0, 1'b1, 1'b0);
    // reset in the middle of DATA after one word has been written
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    ea_q.push_back(32'd0);
    ed_q.push_back(32'h11223344);
    send_byte(8'h44);
    send_byte(8'h33);
    send_byte(8'h22);
    word_end = 1'b1;
    send_byte(8'h11);
    check("abort first write", 32'(ea_q.size()), 32'd0);
    send_byte(8'h55);
    bit_time(1'b0);
    bit_time(1'b1, 4);
    rst_n = 1'b0;
    rx = 1'b1;
    #2;
    check("abort wr_en", 32'(wr_en), 32'd0);
    check("abort wr_addr", 32'(wr_addr), 32'd0);
    check("abort wr_instr", wr_instr, 32'd0);
    flags("abort", 1'b0, 1'b0, 1'b0);
    last_a = '0;
    last_d = '0;
    word_end = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bit_time(1'b1, 20);
    img = '{32'hAABBCCDD, 32'h0, 32'h0, 32'h0};
    load_image(1'b1, 1, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
